// File: rtl/clkdiv_pkg.sv
// Shared definitions for the divide-ratio sequencer: default widths, reset ratio and FSM states.
// Ports: none (package only).
// Imported by div_ratio_sequencer; period_counter uses the defaults by explicit scope.
package clkdiv_pkg;

  localparam int WIDTH       = 8;
  localparam int DEFAULT_DIV = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2,
    STOP = 2'd3
  } state_t;

endpackage

// File: rtl/period_counter.sv
// Mod-N period counter with synchronous clear, terminal-count flag and a modulus register
// that can be loaded at once (set_mod) or deferred to the next wrap (wrap_load).
// Ports: clock/rst, clear, advance, set_mod, wrap_load, mod_in -> cnt, modulus, tc, cnt_nxt, mod_nxt.
module period_counter #(
  parameter int WIDTH       = clkdiv_pkg::WIDTH,
  parameter int DEFAULT_DIV = clkdiv_pkg::DEFAULT_DIV
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             clear,
  input  logic             advance,
  input  logic             set_mod,
  input  logic             wrap_load,
  input  logic [WIDTH-1:0] mod_in,
  output logic [WIDTH-1:0] cnt,
  output logic [WIDTH-1:0] modulus,
  output logic             tc,
  output logic [WIDTH-1:0] cnt_nxt,
  output logic [WIDTH-1:0] mod_nxt
);

  // modulus is never below 2, so modulus-1 cannot underflow and cnt+1 below
  // the terminal count cannot overflow even at modulus = 2^WIDTH-1.
  assign tc = (cnt == modulus - WIDTH'(1));

  always_comb begin
    cnt_nxt = cnt;
    mod_nxt = modulus;
    if (clear) begin
      cnt_nxt = '0;
    end else if (advance) begin
      cnt_nxt = tc ? '0 : cnt + WIDTH'(1);
    end
    if (set_mod) begin
      mod_nxt = mod_in;
    end else if (wrap_load && advance && tc) begin
      mod_nxt = mod_in;
    end
  end

  always_ff @(posedge clock) begin
    if (!rst) begin
      cnt     <= '0;
      modulus <= WIDTH'(DEFAULT_DIV);
    end else begin
      cnt     <= cnt_nxt;
      modulus <= mod_nxt;
    end
  end

endmodule

// File: rtl/div_ratio_sequencer.sv
// Programmable clock divider whose ratio can be changed glitch-free at period boundaries.
// Ports: clock, rst (sync active-low), enable, cfg_valid/cfg_div/cfg_ready handshake,
//        out_clock, tick, cur_div, cfg_err, busy (all outputs registered).
module div_ratio_sequencer #(
  parameter int WIDTH       = clkdiv_pkg::WIDTH,
  parameter int DEFAULT_DIV = clkdiv_pkg::DEFAULT_DIV
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             enable,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             out_clock,
  output logic             tick,
  output logic [WIDTH-1:0] cur_div,
  output logic             cfg_err,
  output logic             busy
);

  import clkdiv_pkg::*;

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] pend_div;
  logic [WIDTH-1:0] pend_div_n;
  logic             err_n;

  logic             clear;
  logic             advance;
  logic             set_mod;
  logic             wrap_load;
  logic [WIDTH-1:0] mod_in;
  logic [WIDTH-1:0] cnt;
  logic             tc;
  logic [WIDTH-1:0] cnt_nxt;
  logic [WIDTH-1:0] mod_nxt;

  logic             hs;
  logic             legal;

  assign hs    = cfg_valid & cfg_ready;
  assign legal = (cfg_div >= WIDTH'(2));

  period_counter #(
    .WIDTH       (WIDTH),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) u_period_counter (
    .clock     (clock),
    .rst       (rst),
    .clear     (clear),
    .advance   (advance),
    .set_mod   (set_mod),
    .wrap_load (wrap_load),
    .mod_in    (mod_in),
    .cnt       (cnt),
    .modulus   (cur_div),
    .tc        (tc),
    .cnt_nxt   (cnt_nxt),
    .mod_nxt   (mod_nxt)
  );

  always_comb begin
    state_n    = state;
    pend_div_n = pend_div;
    err_n      = hs & ~legal;
    clear      = 1'b0;
    advance    = 1'b0;
    set_mod    = 1'b0;
    wrap_load  = 1'b0;
    mod_in     = cfg_div;

    case (state)
      IDLE: begin
        // Counter parks at 0 so the first RUN cycle starts a fresh period.
        clear = 1'b1;
        if (hs && legal) begin
          set_mod = 1'b1;
        end
        if (enable) begin
          state_n = RUN;
        end
      end
      RUN: begin
        advance = 1'b1;
        if (hs && legal) begin
          pend_div_n = cfg_div;
          state_n    = PEND;
        end else if (!enable) begin
          // Dropping enable on the last count ends the period right here,
          // so there is nothing left for STOP to finish.
          state_n = tc ? IDLE : STOP;
        end
      end
      PEND: begin
        advance = 1'b1;
        mod_in  = pend_div;
        if (tc) begin
          // The switch happens exactly at the wrap: next cycle is cnt=0 at the new ratio.
          wrap_load = 1'b1;
          state_n   = enable ? RUN : IDLE;
        end
      end
      STOP: begin
        advance = 1'b1;
        if (enable) begin
          state_n = RUN;
        end else if (tc) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next-state values, so they line up with
  // the state/count of the cycle they describe and never glitch.
  always_ff @(posedge clock) begin
    if (!rst) begin
      state     <= IDLE;
      pend_div  <= WIDTH'(DEFAULT_DIV);
      out_clock <= 1'b0;
      tick      <= 1'b0;
      cfg_err   <= 1'b0;
      busy      <= 1'b0;
      cfg_ready <= 1'b1;
    end else begin
      state     <= state_n;
      pend_div  <= pend_div_n;
      out_clock <= (state_n != IDLE) && (cnt_nxt < (mod_nxt >> 1));
      tick      <= (state_n != IDLE) && (cnt_nxt == '0);
      cfg_err   <= err_n;
      busy      <= (state_n != IDLE);
      cfg_ready <= (state_n == IDLE) || (state_n == RUN);
    end
  end

endmodule

// File: tb/tb_div_ratio_sequencer.sv
// Self-checking bench: behavioural reference model compared against the DUT every cycle,
// directed scenarios with literal expectations, then randomized stimulus.
module tb_div_ratio_sequencer;

  localparam int W = 8;

  logic         clock = 1'b0;
  logic         rst = 1'b0;
  logic         enable = 1'b0;
  logic         cfg_valid = 1'b0;
  logic [W-1:0] cfg_div = '0;
  logic         cfg_ready;
  logic         out_clock;
  logic         tick;
  logic [W-1:0] cur_div;
  logic         cfg_err;
  logic         busy;

  int errors = 0;
  int checks = 0;

  div_ratio_sequencer #(.WIDTH(W), .DEFAULT_DIV(2)) dut (
    .clock     (clock),
    .rst       (rst),
    .enable    (enable),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .out_clock (out_clock),
    .tick      (tick),
    .cur_div   (cur_div),
    .cfg_err   (cfg_err),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the divider is described as "running or not", a period
  // length, a position within the period, an optional queued ratio and a
  // "winding down" flag.
  bit m_valid = 0;
  bit m_on    = 0;
  int m_n     = 2;
  int m_cnt   = 0;
  int m_pend  = -1;
  bit m_stop  = 0;
  bit m_err   = 0;

  always @(posedge clock) begin : model
    bit ready, hs, legal, last;
    int nxt;
    if (!rst) begin
      m_valid = 1; m_on = 0; m_n = 2; m_cnt = 0; m_pend = -1; m_stop = 0; m_err = 0;
    end else if (m_valid) begin
      ready = !m_on || (m_pend < 0 && !m_stop);
      hs    = cfg_valid && ready;
      legal = hs && (int'(cfg_div) >= 2);
      m_err = hs && (int'(cfg_div) < 2);
      if (!m_on) begin
        if (legal) m_n = int'(cfg_div);
        if (enable) begin
          m_on = 1; m_cnt = 0;
        end
      end else begin
        last = (m_cnt == m_n - 1);
        nxt  = last ? 0 : m_cnt + 1;
        if (m_pend >= 0) begin
          if (last) begin
            m_n = m_pend; m_pend = -1; m_on = enable;
          end
        end else if (m_stop) begin
          if (enable) m_stop = 0;
          else if (last) begin m_on = 0; m_stop = 0; end
        end else if (legal) begin
          m_pend = int'(cfg_div);
        end else if (!enable) begin
          if (last) m_on = 0;
          else m_stop = 1;
        end
        m_cnt = m_on ? nxt : 0;
      end
    end
    #2;
    if (m_valid) begin
      chk("out_clock", out_clock, m_on && (m_cnt < m_n / 2));
      chk("tick", tick, m_on && (m_cnt == 0));
      chk("cur_div", cur_div, m_n);
      chk("cfg_err", cfg_err, m_err);
      chk("busy", busy, m_on);
      chk("cfg_ready", cfg_ready, !m_on || (m_pend < 0 && !m_stop));
    end
  end

  task automatic wait_idle(input string name);
    bit done = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clock);
      if (busy === 1'b0) begin
        done = 1;
        break;
      end
    end
    chk({name, "_idle_timeout"}, done, 1);
  endtask

  initial begin : stim
    logic [7:0] pat;
    logic [7:0] tpat;
    int n, highs, ticks;

    // Reset
    repeat (2) @(negedge clock);
    chk("rst_cur_div", cur_div, 2);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_out_clock", out_clock, 0);
    chk("rst_tick", tick, 0);
    rst = 1'b1;

    // Ratio 4 loaded in IDLE, then enable: 1100 repeating, tick every 4th cycle
    cfg_valid = 1'b1; cfg_div = 8'd4;
    @(negedge clock);
    cfg_valid = 1'b0;
    enable = 1'b1;
    pat = '0; tpat = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      pat  = {pat[6:0], out_clock};
      tpat = {tpat[6:0], tick};
    end
    chk("n4_out_pattern", pat, 8'b1100_1100);
    chk("n4_tick_pattern", tpat, 8'b1000_1000);

    // Switch 4 -> 7 accepted at cnt=1
    @(negedge clock);
    chk("n4_tick_cnt0", tick, 1);
    @(negedge clock);
    cfg_valid = 1'b1; cfg_div = 8'd7;
    @(negedge clock);
    cfg_valid = 1'b0;
    chk("pend_ready_cnt2", cfg_ready, 0);
    @(negedge clock);
    chk("pend_ready_cnt3", cfg_ready, 0);
    chk("pend_out_cnt3", out_clock, 0);
    pat = '0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      pat = {pat[6:0], out_clock};
    end
    chk("n7_out_pattern", pat, 8'b0111_0000);
    chk("n7_cur_div", cur_div, 7);

    // Illegal ratios 1 and 0 in RUN
    cfg_valid = 1'b1; cfg_div = 8'd1;
    @(negedge clock);
    chk("err_div1", cfg_err, 1);
    cfg_div = 8'd0;
    @(negedge clock);
    chk("err_div0", cfg_err, 1);
    cfg_valid = 1'b0;
    @(negedge clock);
    chk("err_clears", cfg_err, 0);
    chk("err_cur_div", cur_div, 7);

    // Enable dropped at cnt=1 of N=6: four more cycles, then IDLE
    enable = 1'b0;
    wait_idle("n7_stop");
    cfg_valid = 1'b1; cfg_div = 8'd6; enable = 1'b1;
    @(negedge clock);
    cfg_valid = 1'b0;
    chk("n6_first_tick", tick, 1);
    @(negedge clock);
    enable = 1'b0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (busy) n++;
    end
    chk("n6_stop_cycles", n, 4);
    chk("n6_stop_out", out_clock, 0);
    chk("n6_stop_busy", busy, 0);

    // Reset while PEND at N=3 with 9 queued
    cfg_valid = 1'b1; cfg_div = 8'd3; enable = 1'b1;
    @(negedge clock);
    cfg_div = 8'd9;
    @(negedge clock);
    cfg_valid = 1'b0;
    chk("n3_pend_ready", cfg_ready, 0);
    rst = 1'b0;
    @(negedge clock);
    chk("rstpend_busy", busy, 0);
    chk("rstpend_cur_div", cur_div, 2);
    chk("rstpend_out", out_clock, 0);
    rst = 1'b1;
    pat = '0; tpat = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      pat  = {pat[6:0], out_clock};
      tpat = {tpat[6:0], tick};
    end
    chk("n2_out_pattern", pat, 8'b0000_1010);
    chk("n2_tick_pattern", tpat, 8'b0000_1010);

    // Maximum ratio 255
    enable = 1'b0;
    wait_idle("n2_stop");
    cfg_valid = 1'b1; cfg_div = 8'd255; enable = 1'b1;
    highs = 0; ticks = 0;
    for (int i = 0; i < 255; i++) begin
      @(negedge clock);
      cfg_valid = 1'b0;
      if (out_clock) highs++;
      if (tick) ticks++;
    end
    chk("n255_highs", highs, 127);
    chk("n255_ticks", ticks, 1);
    chk("n255_cur_div", cur_div, 255);
    @(negedge clock);
    chk("n255_wrap_tick", tick, 1);
    chk("n255_wrap_out", out_clock, 1);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      @(negedge clock);
      rst       = ($urandom_range(0, 199) != 0);
      enable    = ($urandom_range(0, 9) < 8);
      cfg_valid = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 9))
        0:       cfg_div = 8'd0;
        1:       cfg_div = 8'd1;
        2:       cfg_div = 8'($urandom_range(2, 40));
        default: cfg_div = 8'($urandom_range(2, 9));
      endcase
    end
    rst = 1'b1; enable = 1'b0; cfg_valid = 1'b0;
    repeat (3) @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
